ps2_kbd_ascii: RTL and testbench
================================

// Module: ps2_kbd_ascii
// PURPOSE
//  PS/2 keyboard front end that produces the held-key ASCII byte `kbdata` consumed by the typing-game memory/VGA logic.
//  It samples ps2_clk/ps2_data, assembles 11-bit frames and buffers the bytes in a small FIFO.
//  A make/break state machine decodes the bytes into `kbdata`.
//  `kbdata` holds the ASCII code of the currently pressed key and returns to 0 on release, so level-polling consumers work.
// PARAMETERS
//  TIMEOUT_CYC  25000  clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms @ 25 MHz)
//  FIFO_DEPTH   8      byte FIFO entries between frame receiver and decoder; power of two, >=2
// PORTS
//  clk        in   1  system clock (25 MHz domain shared with VGA/memory logic)
//  rst_n      in   1  asynchronous, active-low reset
//  ps2_clk    in   1  raw PS/2 clock from the keyboard (asynchronous)
//  ps2_data   in   1  raw PS/2 data from the keyboard (asynchronous)
//  kbdata     out  8  ASCII code of the held key; 0 = no mapped key held
//  scancode   out  8  last raw byte popped from the FIFO
//  key_valid  out  1  1-cycle pulse on every make (including typematic repeat) of a mapped key
//  frame_err  out  1  1-cycle pulse on a parity, start-bit, stop-bit or timeout error
//  overflow   out  1  sticky; set when a byte is dropped because the FIFO is full; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs are 0, FIFO empty, FSM in IDLE, bit counter 0.
//  Sync: ps2_clk and ps2_data each pass through 3 flops. fall = sync2 & ~sync1 is a 1-cycle strobe; data is sampled on fall.
//  Frame format: start(0), D0..D7 LSB first, odd parity, stop(1). Bit counter 0..10.
//  - Start bit = 1 on the first edge: ignore it, counter stays 0, no error.
//  - Parity or stop bit wrong: byte discarded, frame_err pulses at T+1.
//  - Idle counter runs while the bit counter is nonzero.
//    - If it reaches TIMEOUT_CYC: counter -> 0, partial byte discarded, frame_err pulses.
//    - The idle counter resets on every fall.
//  Latency (T = cycle of fall for the stop bit):
//  - good byte written to the FIFO at T+1
//  - decoder pops at T+2
//  - scancode, kbdata and key_valid update at T+3
//  FIFO behaviour:
//  - Push when full and no pop in the same cycle: byte dropped, overflow <= 1.
//  - Push and pop in the same cycle when full: both happen, no drop.
//  - Pop when empty: does not occur.
//  Decoder FSM (one popped byte per cycle max):
//  - IDLE: F0 -> BRK; E0 -> EXT; otherwise MAKE handling, stay IDLE.
//  - BRK: code == held code -> kbdata <= 0; other codes ignored; -> IDLE.
//  - EXT: F0 -> EXT_BRK; any other byte ignored -> IDLE. Extended keys never change kbdata.
//  - EXT_BRK: any byte ignored -> IDLE.
//  - MAKE: if ascii(code) != 0 then kbdata <= ascii, held <= code, key_valid pulses. Repeats re-pulse with kbdata unchanged.
//    A new make of a different key replaces kbdata. Unmapped makes leave kbdata and held unchanged.
//  Mapping (set 2):
//  - letters -> uppercase 65..90 (1C->'A', 32->'B', ..., 1A->'Z')
//  - digits 45,16,1E,26,25,2E,36,3D,3E,46 -> 48..57
//  - 29 -> 32 (space)
//  - everything else -> 0
//  - No shift/caps handling.
//  Reset mid-frame or mid-sequence: everything returns to reset state. The first frame after release starts clean.
// STRUCTURE
//  Package ps2_pkg:
//  - constants PS2_BRK=8'hF0 and PS2_EXT=8'hE0
//  - decoder state enum {IDLE,BRK,EXT,EXT_BRK}
//  - function ascii_of(code) (combinational set-2 lookup)
//  Sub-module ps2_frame_rx: sync, edge detect, bit counter, parity and timeout checks. Outputs rx_byte, rx_valid, rx_err.
//  FIFO and decoder FSM live in this top.
// TESTING
//  1. Frame 1C (A press) -> T+3: kbdata=0x41, scancode=0x1C, key_valid one pulse; frame_err=0.
//  2. Frames 1C, F0, 1C -> kbdata 0x41, then 0x00 after the third byte; key_valid pulsed once.
//  3. 1C held then 16 make, then F0 1C -> kbdata 0x41 -> 0x31. Break of 1C is ignored, kbdata stays 0x31; F0 16 -> 0x00.
//  4. Byte 1C with even parity -> frame_err pulse, kbdata stays 0. Half frame then TIMEOUT_CYC idle -> frame_err, next good 29 -> kbdata=0x20.
//  5. Decoder held off, 9 bytes (FIFO_DEPTH+1) sent back-to-back -> overflow=1. First 8 bytes decoded in order; overflow stays 1.
//  6. E0 75, E0 F0 75 -> kbdata stays 0; then rst_n low mid-frame -> all outputs 0, next 1C decodes to 0x41.

Source files
------------

// File: rtl/ps2_kbd_ascii_pkg.sv
// Shared constants, decoder states and the scan-code-set-2 to ASCII lookup
// used by the PS/2 keyboard front end.
package ps2_pkg;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } dec_state_t;

    // Letters map to uppercase only; anything not listed is treated as unmapped (0).
    function automatic logic [7:0] ascii_of(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h41;
            8'h32: a = 8'h42;
            8'h21: a = 8'h43;
            8'h23: a = 8'h44;
            8'h24: a = 8'h45;
            8'h2B: a = 8'h46;
            8'h34: a = 8'h47;
            8'h33: a = 8'h48;
            8'h43: a = 8'h49;
            8'h3B: a = 8'h4A;
            8'h42: a = 8'h4B;
            8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;
            8'h31: a = 8'h4E;
            8'h44: a = 8'h4F;
            8'h4D: a = 8'h50;
            8'h15: a = 8'h51;
            8'h2D: a = 8'h52;
            8'h1B: a = 8'h53;
            8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;
            8'h2A: a = 8'h56;
            8'h1D: a = 8'h57;
            8'h22: a = 8'h58;
            8'h35: a = 8'h59;
            8'h1A: a = 8'h5A;
            8'h45: a = 8'h30;
            8'h16: a = 8'h31;
            8'h1E: a = 8'h32;
            8'h26: a = 8'h33;
            8'h25: a = 8'h34;
            8'h2E: a = 8'h35;
            8'h36: a = 8'h36;
            8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ps2_kbd_ascii_frame_rx.sv
// PS/2 frame receiver: synchronises the keyboard lines, assembles 11-bit frames
// and reports each good byte or a framing/parity/timeout error as a 1-cycle pulse.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]        r_clk_sync;
    logic [2:0]        r_data_sync;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [7:0]        r_rx_byte;
    logic              r_rx_valid;
    logic              r_rx_err;
    logic              w_fall;
    logic              w_bit;

    // Idle lines are high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 3'b111;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
            r_data_sync <= {r_data_sync[1:0], ps2_data};
        end
    end

    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit  = r_data_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_parity   <= 1'b0;
            r_idle_cnt <= '0;
            r_rx_byte  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            if (w_fall) begin
                r_idle_cnt <= '0;
                case (r_bit_cnt)
                    4'd0: begin
                        if (!w_bit) begin
                            r_bit_cnt <= 4'd1;
                        end
                    end
                    4'd9: begin
                        r_parity  <= w_bit;
                        r_bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        r_bit_cnt <= 4'd0;
                        if (w_bit && (^{r_shift, r_parity})) begin
                            r_rx_byte  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                endcase
            end else if (r_bit_cnt != 4'd0) begin
                // A keyboard that stops clocking mid-frame must not wedge the receiver.
                if (r_idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    r_bit_cnt  <= 4'd0;
                    r_idle_cnt <= '0;
                    r_rx_err   <= 1'b1;
                end else begin
                    r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign rx_byte  = r_rx_byte;
    assign rx_valid = r_rx_valid;
    assign rx_err   = r_rx_err;

endmodule

// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard front end: frame receiver, byte FIFO and make/break decoder that
// presents the ASCII code of the held key as a level for polling consumers.
module ps2_kbd_ascii
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 25000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kbdata,
    output logic [7:0] scancode,
    output logic       key_valid,
    output logic       frame_err,
    output logic       overflow
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [7:0]       w_rx_byte;
    logic             w_rx_valid;
    logic             w_rx_err;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_overflow;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_rd_data;

    dec_state_t       r_state;
    dec_state_t       w_state_nxt;
    logic [7:0]       r_kbdata;
    logic [7:0]       r_held;
    logic [7:0]       r_scancode;
    logic             r_key_valid;
    logic [7:0]       w_kbdata_nxt;
    logic [7:0]       w_held_nxt;
    logic             w_key_valid_nxt;
    logic [7:0]       w_ascii;

    ps2_frame_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (w_rx_byte),
        .rx_valid (w_rx_valid),
        .rx_err   (w_rx_err)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                       (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign w_pop     = ~w_empty;
    assign w_push    = w_rx_valid & (~w_full | w_pop);
    assign w_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_rx_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_kbdata    <= 8'h00;
            r_held      <= 8'h00;
            r_scancode  <= 8'h00;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_kbdata    <= w_kbdata_nxt;
            r_held      <= w_held_nxt;
            r_key_valid <= w_key_valid_nxt;
            if (w_pop) begin
                r_scancode <= w_rd_data;
            end
        end
    end

    // The held code is remembered so only the break of that same key clears kbdata.
    always_comb begin
        w_state_nxt     = r_state;
        w_kbdata_nxt    = r_kbdata;
        w_held_nxt      = r_held;
        w_key_valid_nxt = 1'b0;
        w_ascii         = ascii_of(w_rd_data);
        if (w_pop) begin
            case (r_state)
                IDLE: begin
                    if (w_rd_data == PS2_BRK) begin
                        w_state_nxt = BRK;
                    end else if (w_rd_data == PS2_EXT) begin
                        w_state_nxt = EXT;
                    end else if (w_ascii != 8'h00) begin
                        w_kbdata_nxt    = w_ascii;
                        w_held_nxt      = w_rd_data;
                        w_key_valid_nxt = 1'b1;
                    end
                end
                BRK: begin
                    if (w_rd_data == r_held) begin
                        w_kbdata_nxt = 8'h00;
                    end
                    w_state_nxt = IDLE;
                end
                EXT: begin
                    w_state_nxt = (w_rd_data == PS2_BRK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign kbdata    = r_kbdata;
    assign scancode  = r_scancode;
    assign key_valid = r_key_valid;
    assign frame_err = w_rx_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Self-checking bench for ps2_kbd_ascii: table-driven single-frame vectors followed
// by hand-written sequences for latency, errors, timeout, overflow and reset.
module tb_ps2_kbd_ascii;

    localparam int TIMEOUT_CYC = 200;
    localparam int FIFO_DEPTH  = 8;
    localparam int HALF        = 10;
    localparam int NV          = 19;

    typedef struct {
        logic [7:0] code;
        bit         badPar;
        logic [7:0] expKb;
        logic [7:0] expSc;
        int         expKv;
        int         expErr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] kbdata;
    logic [7:0] scancode;
    logic       keyValid;
    logic       frameErr;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int kvCount  = 0;
    int errCount = 0;
    int kvCyc    = -1;
    int errCyc   = -1;
    int stopCyc  = -1;
    int kv0;
    int e0;

    vec_t       vecs [NV];
    logic [7:0] ovfCodes [9];
    logic [7:0] ovfAscii [8];

    ps2_kbd_ascii #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2Clk),
        .ps2_data  (ps2Data),
        .kbdata    (kbdata),
        .scancode  (scancode),
        .key_valid (keyValid),
        .frame_err (frameErr),
        .overflow  (overflow)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled mid-cycle, recording when the last pulse was seen.
    always @(negedge clk) begin
        if (keyValid) begin
            kvCount++;
            kvCyc = cyc;
        end
        if (frameErr) begin
            errCount++;
            errCyc = cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2Bit(input logic b);
        @(negedge clk);
        ps2Data = b;
        repeat (HALF) @(negedge clk);
        ps2Clk  = 1'b0;
        stopCyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2Clk  = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input bit badPar);
        logic par;
        par = ~^code;
        if (badPar) par = ~par;
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(code[i]);
        ps2Bit(par);
        ps2Bit(1'b1);
        waitCycles(4);
    endtask

    initial begin
        rst_n   = 1'b0;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;

        vecs[0]  = '{8'h1C, 1'b0, 8'h41, 8'h1C, 1, 0};
        vecs[1]  = '{8'hF0, 1'b0, 8'h41, 8'hF0, 0, 0};
        vecs[2]  = '{8'h1C, 1'b0, 8'h00, 8'h1C, 0, 0};
        vecs[3]  = '{8'h1C, 1'b0, 8'h41, 8'h1C, 1, 0};
        vecs[4]  = '{8'h16, 1'b0, 8'h31, 8'h16, 1, 0};
        vecs[5]  = '{8'hF0, 1'b0, 8'h31, 8'hF0, 0, 0};
        vecs[6]  = '{8'h1C, 1'b0, 8'h31, 8'h1C, 0, 0};
        vecs[7]  = '{8'hF0, 1'b0, 8'h31, 8'hF0, 0, 0};
        vecs[8]  = '{8'h16, 1'b0, 8'h00, 8'h16, 0, 0};
        vecs[9]  = '{8'h1C, 1'b1, 8'h00, 8'h16, 0, 1};
        vecs[10] = '{8'h29, 1'b0, 8'h20, 8'h29, 1, 0};
        vecs[11] = '{8'h29, 1'b0, 8'h20, 8'h29, 1, 0};
        vecs[12] = '{8'h76, 1'b0, 8'h20, 8'h76, 0, 0};
        vecs[13] = '{8'h45, 1'b0, 8'h30, 8'h45, 1, 0};
        vecs[14] = '{8'h1A, 1'b0, 8'h5A, 8'h1A, 1, 0};
        vecs[15] = '{8'h46, 1'b0, 8'h39, 8'h46, 1, 0};
        vecs[16] = '{8'h3A, 1'b0, 8'h4D, 8'h3A, 1, 0};
        vecs[17] = '{8'hF0, 1'b0, 8'h4D, 8'hF0, 0, 0};
        vecs[18] = '{8'h3A, 1'b0, 8'h00, 8'h3A, 0, 0};

        ovfCodes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        ovfAscii = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};

        waitCycles(5);
        checkOutput("reset kbdata",    32'(kbdata),    32'h0);
        checkOutput("reset scancode",  32'(scancode),  32'h0);
        checkOutput("reset key_valid", 32'(keyValid),  32'h0);
        checkOutput("reset frame_err", 32'(frameErr),  32'h0);
        checkOutput("reset overflow",  32'(overflow),  32'h0);
        rst_n = 1'b1;
        waitCycles(5);

        for (int i = 0; i < NV; i++) begin
            kv0 = kvCount;
            e0  = errCount;
            applyStimulus(vecs[i].code, vecs[i].badPar);
            checkOutput($sformatf("vec%0d kbdata", i),    32'(kbdata),       32'(vecs[i].expKb));
            checkOutput($sformatf("vec%0d scancode", i),  32'(scancode),     32'(vecs[i].expSc));
            checkOutput($sformatf("vec%0d key_valid", i), 32'(kvCount - kv0), 32'(vecs[i].expKv));
            checkOutput($sformatf("vec%0d frame_err", i), 32'(errCount - e0), 32'(vecs[i].expErr));
        end

        // Good byte: outputs appear 5 posedges after the stop-bit fall is driven.
        kv0 = kvCount;
        applyStimulus(8'h1A, 1'b0);
        checkOutput("latency kbdata",  32'(kbdata),          32'h5A);
        checkOutput("latency cycles",  32'(kvCyc - stopCyc), 32'd5);
        checkOutput("latency pulses",  32'(kvCount - kv0),   32'd1);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h1A, 1'b0);
        checkOutput("release Z", 32'(kbdata), 32'h00);

        e0 = errCount;
        applyStimulus(8'h29, 1'b1);
        checkOutput("parity err count",   32'(errCount - e0),    32'd1);
        checkOutput("parity err latency", 32'(errCyc - stopCyc), 32'd3);
        checkOutput("parity err kbdata",  32'(kbdata),           32'h00);

        e0 = errCount;
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b0);
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        waitCycles(TIMEOUT_CYC + 40);
        checkOutput("timeout err count", 32'(errCount - e0), 32'd1);
        checkOutput("timeout kbdata",    32'(kbdata),        32'h00);
        applyStimulus(8'h29, 1'b0);
        checkOutput("after timeout kbdata",   32'(kbdata),        32'h20);
        checkOutput("after timeout err",      32'(errCount - e0), 32'd1);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h29, 1'b0);

        e0 = errCount;
        ps2Bit(1'b1);
        waitCycles(4);
        applyStimulus(8'h16, 1'b0);
        checkOutput("high start kbdata",   32'(kbdata),        32'h31);
        checkOutput("high start scancode", 32'(scancode),      32'h16);
        checkOutput("high start err",      32'(errCount - e0), 32'd0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h16, 1'b0);
        checkOutput("release 1", 32'(kbdata), 32'h00);

        force dut.w_pop = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(ovfCodes[i], 1'b0);
        checkOutput("fifo full no overflow", 32'(overflow), 32'd0);
        checkOutput("fifo held scancode",    32'(scancode), 32'h16);
        applyStimulus(ovfCodes[8], 1'b0);
        checkOutput("fifo overflow set", 32'(overflow), 32'd1);
        @(negedge clk);
        release dut.w_pop;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("drain%0d scancode", i),  32'(scancode), 32'(ovfCodes[i]));
            checkOutput($sformatf("drain%0d kbdata", i),    32'(kbdata),   32'(ovfAscii[i]));
            checkOutput($sformatf("drain%0d key_valid", i), 32'(keyValid), 32'd1);
        end
        @(negedge clk);
        checkOutput("drain end key_valid", 32'(keyValid), 32'd0);
        checkOutput("drain end scancode",  32'(scancode), 32'h33);
        checkOutput("overflow sticky",     32'(overflow), 32'd1);

        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h33, 1'b0);
        checkOutput("release H", 32'(kbdata), 32'h00);
        kv0 = kvCount;
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h75, 1'b0);
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h75, 1'b0);
        checkOutput("ext kbdata",   32'(kbdata),   32'h00);
        checkOutput("ext scancode", 32'(scancode), 32'h75);
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h29, 1'b0);
        checkOutput("ext mapped kbdata", 32'(kbdata),        32'h00);
        checkOutput("ext key_valid",     32'(kvCount - kv0), 32'd0);
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h29, 1'b0);

        ps2Bit(1'b0);
        ps2Bit(1'b0);
        ps2Bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        waitCycles(3);
        checkOutput("midreset kbdata",    32'(kbdata),   32'h0);
        checkOutput("midreset scancode",  32'(scancode), 32'h0);
        checkOutput("midreset key_valid", 32'(keyValid), 32'h0);
        checkOutput("midreset frame_err", 32'(frameErr), 32'h0);
        checkOutput("midreset overflow",  32'(overflow), 32'h0);
        ps2Data = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(5);
        e0 = errCount;
        applyStimulus(8'h1C, 1'b0);
        checkOutput("post reset kbdata",   32'(kbdata),        32'h41);
        checkOutput("post reset scancode", 32'(scancode),      32'h1C);
        checkOutput("post reset err",      32'(errCount - e0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
